// File: rtl/serdesphy_debug_monitor.sv
// serdesphy_debug_monitor
// Picks one of NUM_CH debug channels and drives it onto the analog debug
// buffer. The channel can be shown live, sample-held at a divided rate, or
// tracked as a running unsigned peak maximum or minimum.
module serdesphy_debug_monitor #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2,
  parameter int DIV_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     dbg_en,
  input  logic [SEL_W-1:0]         dbg_sel,
  input  logic [1:0]               dbg_mode,
  input  logic [DIV_W-1:0]         div_val,
  input  logic                     clr_stats,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [DATA_W-1:0]        debug_analog,
  output logic                     debug_valid,
  output logic                     sel_err
);

  typedef enum logic [1:0] {
    MODE_LIVE = 2'd0,
    MODE_HOLD = 2'd1,
    MODE_MAX  = 2'd2,
    MODE_MIN  = 2'd3
  } mode_e;

  localparam int              NUM_SLOTS = 2 ** SEL_W;
  localparam logic [SEL_W:0]  NUM_CH_W  = (SEL_W + 1)'(NUM_CH);

  // Channel slots beyond NUM_CH read as zero so the select mux is always in range.
  logic [DATA_W-1:0] ch_arr [NUM_SLOTS];

  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_ch
    if (k < NUM_CH) begin : g_real
      assign ch_arr[k] = ch_data[k*DATA_W +: DATA_W];
    end else begin : g_pad
      assign ch_arr[k] = '0;
    end
  end

  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] analog_q, analog_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              first_q, first_d;
  logic [SEL_W-1:0]  sel_prev_q, sel_prev_d;
  logic [1:0]        mode_prev_q, mode_prev_d;
  logic              en_prev_q, en_prev_d;

  logic [DATA_W-1:0] sample;
  logic              sel_bad;
  logic              restart;
  logic              tick;
  mode_e             mode_cur;

  assign sample   = ch_arr[dbg_sel];
  assign sel_bad  = {1'b0, dbg_sel} >= NUM_CH_W;
  assign mode_cur = mode_e'(dbg_mode);
  assign tick     = (cnt_q == div_val);
  assign restart  = clr_stats
                  | (dbg_sel  != sel_prev_q)
                  | (dbg_mode != mode_prev_q)
                  | (dbg_en & ~en_prev_q);

  // Next-state: disable beats restart, restart beats invalid select, then the mode.
  always_comb begin
    cnt_d       = cnt_q;
    analog_d    = analog_q;
    valid_d     = valid_q;
    first_d     = first_q;
    err_d       = 1'b0;
    sel_prev_d  = dbg_sel;
    mode_prev_d = dbg_mode;
    en_prev_d   = dbg_en;

    if (!dbg_en) begin
      cnt_d    = '0;
      analog_d = '0;
      valid_d  = 1'b0;
      first_d  = 1'b1;
    end else begin
      err_d = sel_bad;
      if (restart) begin
        cnt_d    = '0;
        analog_d = '0;
        valid_d  = 1'b0;
        first_d  = 1'b1;
      end else begin
        cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
        if (sel_bad) begin
          analog_d = '0;
          valid_d  = 1'b0;
        end else begin
          case (mode_cur)
            MODE_LIVE: begin
              analog_d = sample;
              valid_d  = 1'b1;
            end
            MODE_HOLD: begin
              if (tick) begin
                analog_d = sample;
                valid_d  = 1'b1;
              end
            end
            MODE_MAX: begin
              if (tick) begin
                valid_d = 1'b1;
                first_d = 1'b0;
                if (first_q || (sample > analog_q)) begin
                  analog_d = sample;
                end
              end
            end
            MODE_MIN: begin
              if (tick) begin
                valid_d = 1'b1;
                first_d = 1'b0;
                if (first_q || (sample < analog_q)) begin
                  analog_d = sample;
                end
              end
            end
            default: begin
              analog_d = analog_q;
            end
          endcase
        end
      end
    end
  end

  // State registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      analog_q    <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      first_q     <= 1'b0;
      sel_prev_q  <= '0;
      mode_prev_q <= '0;
      en_prev_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      analog_q    <= analog_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      first_q     <= first_d;
      sel_prev_q  <= sel_prev_d;
      mode_prev_q <= mode_prev_d;
      en_prev_q   <= en_prev_d;
    end
  end

  assign debug_analog = analog_q;
  assign debug_valid  = valid_q;
  assign sel_err      = err_q;

endmodule

// File: tb/tb_serdesphy_debug_monitor.sv
// Bench for serdesphy_debug_monitor, built with three channels so that
// select value 3 is an invalid channel.
module tb_serdesphy_debug_monitor;

  logic        clk;
  logic        rst_n;
  logic        dbg_en;
  logic [1:0]  dbg_sel;
  logic [1:0]  dbg_mode;
  logic [7:0]  div_val;
  logic        clr_stats;
  logic [7:0]  ch [3];
  logic [23:0] ch_data;
  logic [7:0]  debug_analog;
  logic        debug_valid;
  logic        sel_err;

  int total;
  int bad;

  assign ch_data = {ch[2], ch[1], ch[0]};

  serdesphy_debug_monitor #(
    .NUM_CH(3),
    .DATA_W(8),
    .SEL_W (2),
    .DIV_W (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dbg_en      (dbg_en),
    .dbg_sel     (dbg_sel),
    .dbg_mode    (dbg_mode),
    .div_val     (div_val),
    .clr_stats   (clr_stats),
    .ch_data     (ch_data),
    .debug_analog(debug_analog),
    .debug_valid (debug_valid),
    .sel_err     (sel_err)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: outputs derived from cycles elapsed since the last
  // restart and the list of samples captured since then.
  logic       m_pen;
  logic [1:0] m_psel;
  logic [1:0] m_pmode;
  int         m_age;
  logic [7:0] m_q [$];
  logic [7:0] m_a;
  logic       m_v;
  logic       m_e;

  task automatic modelReset();
    m_pen   = 1'b0;
    m_psel  = 2'd0;
    m_pmode = 2'd0;
    m_age   = 0;
    m_q.delete();
    m_a = 8'h00;
    m_v = 1'b0;
    m_e = 1'b0;
  endtask

  task automatic modelStep();
    logic bad_sel;
    logic is_tick;
    bad_sel = (dbg_sel >= 2'd3);
    if (!dbg_en) begin
      m_a = 8'h00; m_v = 1'b0; m_e = 1'b0;
      m_age = 0;
      m_q.delete();
    end else if (clr_stats || (dbg_sel != m_psel) || (dbg_mode != m_pmode) || !m_pen) begin
      m_a = 8'h00; m_v = 1'b0; m_e = bad_sel;
      m_age = 0;
      m_q.delete();
    end else begin
      m_age++;
      m_e = bad_sel;
      if (bad_sel) begin
        m_a = 8'h00; m_v = 1'b0;
      end else begin
        is_tick = ((m_age % (int'(div_val) + 1)) == 0);
        if (dbg_mode == 2'd0) begin
          m_a = ch[dbg_sel];
          m_v = 1'b1;
        end else begin
          if (is_tick) m_q.push_back(ch[dbg_sel]);
          m_v = (m_q.size() > 0);
          if (m_q.size() == 0) begin
            m_a = 8'h00;
          end else if (dbg_mode == 2'd1) begin
            m_a = m_q[m_q.size()-1];
          end else begin
            m_a = m_q[0];
            foreach (m_q[j]) begin
              if ((dbg_mode == 2'd2) ? (m_q[j] > m_a) : (m_q[j] < m_a)) m_a = m_q[j];
            end
          end
        end
      end
    end
    m_psel  = dbg_sel;
    m_pmode = dbg_mode;
    m_pen   = dbg_en;
  endtask

  task automatic applyStimulus(input logic en, input logic [1:0] sel, input logic [1:0] mode,
                               input logic [7:0] dv, input logic clr,
                               input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
    dbg_en    = en;
    dbg_sel   = sel;
    dbg_mode  = mode;
    div_val   = dv;
    clr_stats = clr;
    ch[0]     = c0;
    ch[1]     = c1;
    ch[2]     = c2;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] ea, input logic ev, input logic ee);
    total++;
    if ((debug_analog !== ea) || (debug_valid !== ev) || (sel_err !== ee)) begin
      bad++;
      $display("[TB] FAIL %s: got analog=%h valid=%b err=%b, want analog=%h valid=%b err=%b",
               name, debug_analog, debug_valid, sel_err, ea, ev, ee);
    end
  endtask

  // One clock: update the model with the present inputs, then sample 1 ns past the edge.
  task automatic cycle();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       en;
    logic [1:0] sel;
    logic [1:0] mode;
    logic [7:0] dv;
    logic       clr;
    logic [7:0] c0;
    logic [7:0] c2;
    logic [7:0] ea;
    logic       ev;
    logic       ee;
  } vec_t;

  vec_t vecs [14];

  initial begin
    total = 0;
    bad   = 0;

    vecs[0]  = '{1'b1, 2'd2, 2'd2, 8'd0, 1'b0, 8'h00, 8'h11, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 2'd2, 2'd2, 8'd0, 1'b0, 8'h00, 8'h30, 8'h30, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 2'd2, 2'd2, 8'd0, 1'b0, 8'h00, 8'h80, 8'h80, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 2'd2, 2'd2, 8'd0, 1'b0, 8'h00, 8'h20, 8'h80, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 2'd2, 2'd2, 8'd0, 1'b0, 8'h00, 8'hFF, 8'hFF, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 2'd2, 2'd2, 8'd0, 1'b0, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 2'd2, 2'd2, 8'd0, 1'b1, 8'h00, 8'h05, 8'h00, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 2'd2, 2'd2, 8'd0, 1'b0, 8'h00, 8'h07, 8'h07, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 2'd2, 2'd2, 8'd0, 1'b0, 8'h00, 8'h09, 8'h09, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 2'd3, 2'd2, 8'd0, 1'b0, 8'h00, 8'h09, 8'h00, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 2'd3, 2'd2, 8'd0, 1'b0, 8'h00, 8'h09, 8'h00, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 2'd0, 2'd2, 8'd0, 1'b0, 8'h44, 8'h09, 8'h00, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 2'd0, 2'd2, 8'd0, 1'b0, 8'h44, 8'h09, 8'h44, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 2'd0, 2'd2, 8'd0, 1'b0, 8'h60, 8'h09, 8'h60, 1'b1, 1'b0};

    // Reset with a live channel waiting behind it.
    rst_n = 1'b0;
    applyStimulus(1'b1, 2'd0, 2'd0, 8'd0, 1'b0, 8'h5A, 8'h00, 8'h00);
    modelReset();
    #12;
    checkOutput("reset_hold", 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    cycle();
    checkOutput("reset_first_edge", 8'h00, 1'b0, 1'b0);
    cycle();
    checkOutput("reset_live", 8'h5A, 1'b1, 1'b0);

    // Sample-hold, divide by 4, channel 1 counting up from 0x10.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(1'b1, 2'd1, 2'd1, 8'd3, 1'b0, 8'h00, 8'(8'h10 + i), 8'h00);
      cycle();
      checkOutput($sformatf("hold_%0d", i),
                  (i < 4) ? 8'h00 : 8'(8'h10 + 4 * (i / 4)), (i >= 4), 1'b0);
    end

    // Peak-max run, clear, then invalid select and return.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].en, vecs[i].sel, vecs[i].mode, vecs[i].dv, vecs[i].clr,
                    vecs[i].c0, 8'h00, vecs[i].c2);
      cycle();
      checkOutput($sformatf("vec%0d", i), vecs[i].ea, vecs[i].ev, vecs[i].ee);
    end

    // Peak-min with a clear landing on a tick.
    applyStimulus(1'b1, 2'd2, 2'd3, 8'd2, 1'b0, 8'h00, 8'h00, 8'h50);
    for (int i = 0; i < 3; i++) begin
      cycle();
      checkOutput($sformatf("min_pre%0d", i), 8'h00, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 2'd2, 2'd3, 8'd2, 1'b1, 8'h00, 8'h00, 8'h10);
    cycle();
    checkOutput("min_clr_tick", 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd2, 2'd3, 8'd2, 1'b0, 8'h00, 8'h00, 8'h90);
    cycle();
    cycle();
    checkOutput("min_wait", 8'h00, 1'b0, 1'b0);
    cycle();
    checkOutput("min_first", 8'h90, 1'b1, 1'b0);
    ch[2] = 8'h20;
    cycle();
    cycle();
    checkOutput("min_hold", 8'h90, 1'b1, 1'b0);
    ch[2] = 8'h60;
    cycle();
    checkOutput("min_lower", 8'h60, 1'b1, 1'b0);

    // Disable mid-capture, then re-enable.
    dbg_en = 1'b0;
    cycle();
    checkOutput("disabled", 8'h00, 1'b0, 1'b0);
    cycle();
    dbg_en = 1'b1;
    ch[2]  = 8'h33;
    cycle();
    checkOutput("reenable", 8'h00, 1'b0, 1'b0);
    cycle();
    cycle();
    checkOutput("reenable_wait", 8'h00, 1'b0, 1'b0);
    cycle();
    checkOutput("reenable_first", 8'h33, 1'b1, 1'b0);

    // Asynchronous reset mid-count.
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 8'h00, 1'b0, 1'b0);
    modelReset();
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Random traffic against the model; div_val only moves together with a clear.
    applyStimulus(1'b1, 2'd0, 2'd0, 8'($urandom_range(0, 4)), 1'b0,
                  8'($urandom), 8'($urandom), 8'($urandom));
    for (int i = 0; i < 600; i++) begin
      cycle();
      checkOutput($sformatf("rand_%0d", i), m_a, m_v, m_e);
      if ($urandom_range(0, 99) < 4)  dbg_en   = ~dbg_en;
      if ($urandom_range(0, 99) < 5)  dbg_sel  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 5)  dbg_mode = 2'($urandom_range(0, 3));
      clr_stats = ($urandom_range(0, 99) < 3);
      if (clr_stats) div_val = 8'($urandom_range(0, 4));
      ch[0] = 8'($urandom);
      ch[1] = 8'($urandom);
      ch[2] = 8'($urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serdesphy_debug_monitor.md
# serdesphy_debug_monitor

Parametrised debug-observation block for the SerDes PHY. It selects one of `NUM_CH` debug channels from the analog and digital blocks and presents it on the analog debug buffer. The selected channel is shown in one of four modes: live, divided-rate sample-and-hold, peak-max or peak-min. It sits between the CSR block and the DBG_ANA output buffer, replacing fixed one-hot debug routing.

## Interface
Parameters:
- `NUM_CH`, 4: number of debug channels (2..16).
- `DATA_W`, 8: width of each channel and of the output.
- `SEL_W`, 2: channel-select width; must satisfy 2**SEL_W >= NUM_CH.
- `DIV_W`, 8: sample-divider width.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: active-low reset, asserted asynchronously.
- `dbg_en` in 1: monitor enable (CSR).
- `dbg_sel` in SEL_W: channel index (CSR).
- `dbg_mode` in 2: 0 = live, 1 = sample-hold, 2 = peak-max, 3 = peak-min (CSR).
- `div_val` in DIV_W: sample period minus one (CSR).
- `clr_stats` in 1: single-cycle pulse that restarts capture and statistics.
- `ch_data` in NUM_CH*DATA_W: channel k occupies bits [k*DATA_W +: DATA_W].
- `debug_analog` out DATA_W: registered debug value.
- `debug_valid` out 1: `debug_analog` holds a real sample.
- `sel_err` out 1: `dbg_sel` >= NUM_CH.

## Operation
- **Reset values.** All outputs and internal state reset to 0: `debug_analog`, `debug_valid`, `sel_err`, the divider counter, the peak register, and the registered previous sel/mode.
- **Restart event.** A restart is any of the following:
  - `clr_stats` = 1;
  - `dbg_sel` differs from the registered previous `dbg_sel`;
  - `dbg_mode` differs from the registered previous `dbg_mode`;
  - a rising edge of `dbg_en`.
- **Effect of a restart.**
  - Divider counter is set to 0.
  - `debug_valid` is set to 0.
  - `debug_analog` is set to 0.
  - Peak "first" flag is set to 1.
  - Any tick in the same cycle is discarded.
- **Divider.**
  - Counter runs 0..`div_val` while enabled; `tick` = (counter == `div_val`), after which the counter wraps to 0.
  - `div_val` = 0 gives a tick every cycle.
  - A change of `div_val` is not a restart; the counter wraps at the new value, or on overflow at 2**DIV_W − 1.
- **Disabled** (`dbg_en` = 0): `debug_analog`, `debug_valid` and `sel_err` are forced to 0, and the counter is held at 0.
- **Invalid select** (enabled, `dbg_sel` >= NUM_CH): `sel_err` = 1, `debug_analog` = 0, `debug_valid` = 0, and the counter keeps running.
- **Live mode:** `debug_analog` <= ch[sel] every cycle; `debug_valid` <= 1.
- **Sample-hold mode:** on a tick, `debug_analog` <= ch[sel] and `debug_valid` <= 1; otherwise hold.
- **Peak-max mode:** on a tick, if first = 1, load the sample and clear first; else load max(current, sample), unsigned compare. `debug_valid` <= 1 on the first tick.
- **Peak-min mode:** same as peak-max but with an unsigned min.
- **Saturation:** peak values saturate naturally within DATA_W; no wrap is possible.

## Timing
- **Live mode:** latency is 1 cycle from `ch_data` to `debug_analog`.
- **Sample-hold and peak modes:** the tick cycle samples `ch_data`, and the result appears on the next edge (1-cycle latency).
- **First tick after a restart:** occurs `div_val`+1 cycles after the restart cycle, because the counter is 0 in the cycle following the restart.
- **Valid-change detection:** `dbg_sel` and `dbg_mode` changes are seen in the same cycle they are applied. Outputs clear on that edge, with no glitch of old-channel data.
- **Precedence:** reset > disabled > restart > invalid select > mode behaviour.
- **Reset mid-operation:** all state clears immediately. After release, if `dbg_en` = 1, operation resumes as after a restart, without needing a rising edge.

## Test plan
- **Reset.** Release `rst_n` with `dbg_en` = 1, sel 0, live mode, ch0 = 0x5A → `debug_analog` = 0x00 during reset; 0x5A with `debug_valid` = 1 one cycle after the first edge.
- **Sample-hold.** Mode 1, `div_val` = 3, ch1 incrementing every cycle from 0x10, sel = 1 set at cycle T → `debug_valid` = 0 until T+5; then updates every 4 cycles with values 0x14, 0x18, …
- **Peak-max.** Mode 2, `div_val` = 0, ch2 sequence 0x30, 0x80, 0x20, 0xFF, 0x00 → `debug_analog` sequence 0x30, 0x80, 0x80, 0xFF, 0xFF. Then `clr_stats` → 0x00 with valid = 0, then the next sample loads directly.
- **Peak-min with simultaneous events.** Mode 3, `clr_stats` coincident with a tick → that sample is discarded; the next tick loads its sample as the new min.
- **Invalid select.** NUM_CH = 3 and `dbg_sel` = 3 → `sel_err` = 1, output 0, valid 0. Returning to sel 0 → `sel_err` = 0 and a restart.
- **Disable and reset mid-run.** Drop `dbg_en` mid-capture → outputs 0. Re-enable → first sample after `div_val`+1 cycles. Assert `rst_n` mid-count → all outputs 0 on the same cycle.
